// File: rtl/pacman_move_ctrl.sv
// Pac-Man movement controller: frame-edge pacing, button request latch, and a
// req/ack wall query to the maze lookup before each grid step.
module pacman_move_ctrl #(
    parameter int unsigned GridW         = 28,
    parameter int unsigned GridH         = 31,
    parameter int unsigned StartX        = 13,
    parameter int unsigned StartY        = 23,
    parameter int unsigned TunnelY       = 14,
    parameter int unsigned FramesPerStep = 8,
    parameter int unsigned AckTimeout    = 15
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       frame_clk_i,
    input  logic       btn_up_i,
    input  logic       btn_down_i,
    input  logic       btn_left_i,
    input  logic       btn_right_i,
    output logic       wall_req_o,
    output logic [4:0] wall_x_o,
    output logic [4:0] wall_y_o,
    input  logic       wall_ack_i,
    input  logic       wall_hit_i,
    output logic [4:0] pos_x_o,
    output logic [4:0] pos_y_o,
    output logic [1:0] dir_o,
    output logic       moved_o
);

    localparam int unsigned FcntW = (FramesPerStep > 1) ? $clog2(FramesPerStep) : 1;
    localparam int unsigned TmoW  = (AckTimeout > 1) ? $clog2(AckTimeout) : 1;
    localparam logic [4:0] XMax   = 5'(GridW - 1);
    localparam logic [4:0] YMax   = 5'(GridH - 1);
    localparam logic [4:0] TunY   = 5'(TunnelY);
    localparam logic [1:0] DirUp = 2'b00, DirDown = 2'b01, DirLeft = 2'b10, DirRight = 2'b11;

    typedef enum logic [1:0] {StIdle, StChkReq, StChkCur, StMove} state_e;

    state_e           state_q, state_d;
    logic             s1_q, s2_q, s3_q;
    logic [1:0]       warm_q;
    logic [FcntW-1:0] fcnt_q, fcnt_d;
    logic             req_valid_q, req_valid_d;
    logic [1:0]       req_dir_q, req_dir_d;
    logic             wall_req_q, wall_req_d;
    logic [4:0]       wall_x_q, wall_x_d, wall_y_q, wall_y_d;
    logic [1:0]       qdir_q, qdir_d;
    logic [TmoW-1:0]  tmo_q, tmo_d;
    logic [4:0]       pos_x_q, pos_x_d, pos_y_q, pos_y_d;
    logic [1:0]       dir_q, dir_d;
    logic             moved_q;
    logic             tick, step, take;
    logic [1:0]       qsel_dir;
    logic             tgt_off;
    logic [4:0]       tgt_x, tgt_y;

    // Returns {off_grid, x, y} of the neighbour cell; only the tunnel row wraps.
    function automatic logic [10:0] next_cell(input logic [4:0] x, input logic [4:0] y,
                                              input logic [1:0] d);
        logic       off;
        logic [4:0] nx, ny;
        off = 1'b0;
        nx  = x;
        ny  = y;
        case (d)
            DirUp:    if (y == 5'd0) off = 1'b1; else ny = y - 5'd1;
            DirDown:  if (y == YMax) off = 1'b1; else ny = y + 5'd1;
            DirLeft:  if (x != 5'd0) nx = x - 5'd1; else if (y == TunY) nx = XMax; else off = 1'b1;
            default:  if (x != XMax) nx = x + 5'd1; else if (y == TunY) nx = 5'd0; else off = 1'b1;
        endcase
        return {off, nx, ny};
    endfunction

    // warm_q holds off ticks until s3_q carries a genuine sample of frame_clk_i.
    assign tick = s2_q & ~s3_q & (warm_q == 2'd3);

    always_comb begin
        fcnt_d = fcnt_q;
        step   = 1'b0;
        if (tick) begin
            if (fcnt_q == FcntW'(FramesPerStep - 1)) begin
                fcnt_d = '0;
                step   = 1'b1;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    assign qsel_dir = (state_q == StChkReq) ? req_dir_q : dir_q;
    assign {tgt_off, tgt_x, tgt_y} = next_cell(pos_x_q, pos_y_q, qsel_dir);

    always_comb begin
        state_d    = state_q;
        wall_req_d = wall_req_q;
        wall_x_d   = wall_x_q;
        wall_y_d   = wall_y_q;
        qdir_d     = qdir_q;
        tmo_d      = tmo_q;
        pos_x_d    = pos_x_q;
        pos_y_d    = pos_y_q;
        dir_d      = dir_q;
        take       = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (step) begin
                    state_d = (req_valid_q && req_dir_q != dir_q) ? StChkReq : StChkCur;
                end
            end
            StChkReq, StChkCur: begin
                if (!wall_req_q) begin
                    if (tgt_off) begin
                        state_d = (state_q == StChkReq) ? StChkCur : StIdle;
                    end else begin
                        wall_req_d = 1'b1;
                        wall_x_d   = tgt_x;
                        wall_y_d   = tgt_y;
                        qdir_d     = qsel_dir;
                        tmo_d      = '0;
                    end
                end else if (wall_ack_i) begin
                    wall_req_d = 1'b0;
                    if (!wall_hit_i) begin
                        state_d = StMove;
                        if (state_q == StChkReq) begin
                            dir_d = qdir_q;
                            take  = 1'b1;
                        end
                    end else begin
                        state_d = (state_q == StChkReq) ? StChkCur : StIdle;
                    end
                end else if (tmo_q == TmoW'(AckTimeout - 1)) begin
                    wall_req_d = 1'b0;
                    state_d    = (state_q == StChkReq) ? StChkCur : StIdle;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            StMove: begin
                pos_x_d = wall_x_q;
                pos_y_d = wall_y_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_valid_d = req_valid_q;
        req_dir_d   = req_dir_q;
        if (btn_up_i || btn_down_i || btn_left_i || btn_right_i) begin
            req_valid_d = 1'b1;
            if (btn_up_i)        req_dir_d = DirUp;
            else if (btn_down_i) req_dir_d = DirDown;
            else if (btn_left_i) req_dir_d = DirLeft;
            else                 req_dir_d = DirRight;
        end else if (take) begin
            req_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= StIdle;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            s3_q        <= 1'b0;
            warm_q      <= 2'd0;
            fcnt_q      <= '0;
            req_valid_q <= 1'b0;
            req_dir_q   <= DirUp;
            wall_req_q  <= 1'b0;
            wall_x_q    <= 5'd0;
            wall_y_q    <= 5'd0;
            qdir_q      <= DirUp;
            tmo_q       <= '0;
            pos_x_q     <= 5'(StartX);
            pos_y_q     <= 5'(StartY);
            dir_q       <= DirLeft;
            moved_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            s1_q        <= frame_clk_i;
            s2_q        <= s1_q;
            s3_q        <= s2_q;
            warm_q      <= (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
            fcnt_q      <= fcnt_d;
            req_valid_q <= req_valid_d;
            req_dir_q   <= req_dir_d;
            wall_req_q  <= wall_req_d;
            wall_x_q    <= wall_x_d;
            wall_y_q    <= wall_y_d;
            qdir_q      <= qdir_d;
            tmo_q       <= tmo_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_q       <= dir_d;
            moved_q     <= (state_q == StMove);
        end
    end

    assign wall_req_o = wall_req_q;
    assign wall_x_o   = wall_x_q;
    assign wall_y_o   = wall_y_q;
    assign pos_x_o    = pos_x_q;
    assign pos_y_o    = pos_y_q;
    assign dir_o      = dir_q;
    assign moved_o    = moved_q;

endmodule
